// File: rtl/edp_diag_reader.sv
// EBUS-side diagnostic read sequencer for the EDP: selects a source register,
// waits for the bus, holds the read function while EBUS settles, and returns the captured word.
//
// state   | meaning
// IDLE    | ready for a request
// WAITBUS | waiting for other EBUS drivers to release, bounded by TIMEOUT
// DRIVE   | read function raised, counting SETTLE cycles before capture
// RESP    | response held on the rsp channel until consumed
module edp_diag_reader #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_sel,
    input  logic        req_all,
    input  logic        bus_busy,
    output logic        diag_read_func,
    output logic [2:0]  diag_func,
    input  logic [35:0] ebus_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_sel,
    output logic [35:0] rsp_data,
    output logic        rsp_parity,
    output logic        rsp_timeout,
    output logic        rsp_last
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [WCW-1:0] WAIT_LAST   = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITBUS = 2'd1,
        DRIVE   = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic            sweep_q, sweep_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [SCW-1:0]  settle_cnt_q, settle_cnt_d;
    logic            drive_q, drive_d;
    logic [2:0]      func_q, func_d;
    logic [35:0]     data_q, data_d;
    logic            parity_q, parity_d;
    logic            timeout_q, timeout_d;
    logic            last_q, last_d;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sweep_d      = sweep_q;
        wait_cnt_d   = wait_cnt_q;
        settle_cnt_d = settle_cnt_q;
        drive_d      = drive_q;
        func_d       = func_q;
        data_d       = data_q;
        parity_d     = parity_q;
        timeout_d    = timeout_q;
        last_d       = last_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_d      = req_all ? 3'd0 : req_sel;
                    sweep_d    = req_all;
                    wait_cnt_d = '0;
                    state_d    = WAITBUS;
                end
            end
            WAITBUS: begin
                // A free bus wins over an expiring wait budget.
                if (!bus_busy) begin
                    state_d      = DRIVE;
                    settle_cnt_d = '0;
                    drive_d      = 1'b1;
                    func_d       = sel_q;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = RESP;
                    data_d    = '0;
                    parity_d  = 1'b0;
                    timeout_d = 1'b1;
                    last_d    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                // Collision takes priority over capture; the wait budget is not refreshed.
                if (bus_busy) begin
                    state_d      = WAITBUS;
                    drive_d      = 1'b0;
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d   = RESP;
                    drive_d   = 1'b0;
                    data_d    = ebus_data;
                    parity_d  = ^ebus_data;
                    timeout_d = 1'b0;
                    last_d    = ~sweep_q | (sel_q == 3'd7);
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (sweep_q && (sel_q != 3'd7) && !timeout_q) begin
                        sel_d      = sel_q + 3'd1;
                        wait_cnt_d = '0;
                        state_d    = WAITBUS;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sweep_q      <= 1'b0;
            wait_cnt_q   <= '0;
            settle_cnt_q <= '0;
            drive_q      <= 1'b0;
            func_q       <= '0;
            data_q       <= '0;
            parity_q     <= 1'b0;
            timeout_q    <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sweep_q      <= sweep_d;
            wait_cnt_q   <= wait_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            drive_q      <= drive_d;
            func_q       <= func_d;
            data_q       <= data_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            last_q       <= last_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && !reset;
    assign diag_read_func = drive_q;
    assign diag_func      = func_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_sel        = sel_q;
    assign rsp_data       = data_q;
    assign rsp_parity     = parity_q;
    assign rsp_timeout    = timeout_q;
    assign rsp_last       = last_q;

endmodule
